// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the toggle-handshake memory bus. The arbiter, the CPU
// and the memory module all use these.
//   bus_cmd_t    : 2-bit bus command
//   BUS_CMD_*    : command encodings (read, write, byte read, byte write)
//   arb_state_t  : arbiter FSM states
//   cmd_is_read  : true for commands that return data to the requester
// -----------------------------------------------------------------------------
package bus_pkg;

  typedef logic [1:0] bus_cmd_t;

  localparam bus_cmd_t BUS_CMD_READ    = 2'd0;
  localparam bus_cmd_t BUS_CMD_WRITE   = 2'd1;
  localparam bus_cmd_t BUS_CMD_READ_B  = 2'd2;
  localparam bus_cmd_t BUS_CMD_WRITE_B = 2'd3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic logic cmd_is_read(input bus_cmd_t cmd);
    logic is_rd;
    case (cmd)
      BUS_CMD_READ, BUS_CMD_READ_B:   is_rd = 1'b1;
      BUS_CMD_WRITE, BUS_CMD_WRITE_B: is_rd = 1'b0;
      default:                        is_rd = 1'b0;
    endcase
    return is_rd;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans pend starting one above
// last_grant, wrapping modulo NUM_REQ, and reports the first set bit.
//   pend       : request-pending vector
//   last_grant : index served most recently
//   winner     : index of the selected requester (0 when valid is low)
//   valid      : at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick
  import bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  int               sum_v;
  logic [IDX_W-1:0] idx_v;

  // Priority scan; walking offsets from farthest to nearest lets the nearest
  // pending port (highest round-robin priority) overwrite the others.
  always_comb begin
    winner = {IDX_W{1'b0}};
    valid  = 1'b0;
    sum_v  = 0;
    idx_v  = {IDX_W{1'b0}};
    for (int off = NUM_REQ; off >= 1; off--) begin
      sum_v  = int'(last_grant) + off;
      // last_grant < NUM_REQ and off <= NUM_REQ, so one subtraction wraps
      idx_v  = IDX_W'((sum_v >= NUM_REQ) ? (sum_v - NUM_REQ) : sum_v);
      winner = pend[idx_v] ? idx_v : winner;
      valid  = valid | pend[idx_v];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares one toggle-handshake memory port between NUM_REQ requesters. Each
// requester sees a private run/done toggle pair; one transaction is forwarded
// at a time in round-robin order and only the winner gets data and done.
//   clk, reset_n      : clock, asynchronous active-low reset
//   req_run/req_done  : per-port toggle handshake (pending when they differ)
//   req_cmd/addr/wr_data : per-port command, byte address, write data
//   req_rd_data       : per-port read data register
//   mem_run/cmd/addr/wr_data, mem_rd_data, mem_done : memory-side handshake
//   grant             : one-hot port being served (zero when idle)
//   busy              : a transaction is in flight
//   err               : sticky handshake error seen while idle
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_run,
  input  logic [2*NUM_REQ-1:0]      req_cmd,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W*NUM_REQ-1:0] req_rd_data,
  output logic                      mem_run,
  output logic [1:0]                mem_cmd,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wr_data,
  input  logic [DATA_W-1:0]         mem_rd_data,
  input  logic                      mem_done,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][1:0]        cmd_s;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_s;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdat_s;
  logic [NUM_REQ-1:0]             pend_s;
  logic [IDX_W-1:0]               pick_s;
  logic                           pick_valid_s;
  logic                           err_evt_s;

  arb_state_t                     state_q, state_d;
  logic [IDX_W-1:0]               last_grant_q, last_grant_d;
  logic [IDX_W-1:0]               win_q, win_d;
  logic [NUM_REQ-1:0]             grant_q, grant_d;
  logic                           busy_q, busy_d;
  logic                           err_q, err_d;
  logic                           mem_run_q, mem_run_d;
  bus_cmd_t                       mem_cmd_q, mem_cmd_d;
  logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]              mem_wr_data_q, mem_wr_data_d;
  logic [NUM_REQ-1:0]             req_done_q, req_done_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] rd_q, rd_d;
  logic                           mem_done_prev_q;

  assign cmd_s  = req_cmd;
  assign addr_s = req_addr;
  assign wdat_s = req_wr_data;
  assign pend_s = req_run ^ req_done_q;

  // While idle the memory must be quiet and its done toggle must match run.
  assign err_evt_s = (state_q == ARB_IDLE) &&
                     ((mem_done != mem_done_prev_q) || (mem_run_q != mem_done));

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .pend      (pend_s),
    .last_grant(last_grant_q),
    .winner    (pick_s),
    .valid     (pick_valid_s)
  );

  // Next-state logic: issue from IDLE, retire on matching memory done in BUSY.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    win_d         = win_q;
    grant_d       = grant_q;
    busy_d        = busy_q;
    err_d         = err_q | err_evt_s;
    mem_run_d     = mem_run_q;
    mem_cmd_d     = mem_cmd_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    req_done_d    = req_done_q;
    rd_d          = rd_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          win_d         = pick_s;
          mem_cmd_d     = bus_cmd_t'(cmd_s[pick_s]);
          mem_addr_d    = addr_s[pick_s];
          mem_wr_data_d = wdat_s[pick_s];
          mem_run_d     = ~mem_run_q;
          grant_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
          busy_d        = 1'b1;
          state_d       = ARB_BUSY;
        end else begin
          state_d       = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (mem_done == mem_run_q) begin
          if (cmd_is_read(mem_cmd_q)) begin
            rd_d[win_q] = mem_rd_data;
          end else begin
            rd_d[win_q] = rd_q[win_q];
          end
          req_done_d[win_q] = ~req_done_q[win_q];
          last_grant_d      = win_q;
          grant_d           = {NUM_REQ{1'b0}};
          busy_d            = 1'b0;
          state_d           = ARB_IDLE;
        end else begin
          state_d           = ARB_BUSY;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = {NUM_REQ{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ARB_IDLE;
      last_grant_q    <= IDX_W'(NUM_REQ - 1);
      win_q           <= {IDX_W{1'b0}};
      grant_q         <= {NUM_REQ{1'b0}};
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
      mem_run_q       <= 1'b0;
      mem_cmd_q       <= BUS_CMD_READ;
      mem_addr_q      <= {ADDR_W{1'b0}};
      mem_wr_data_q   <= {DATA_W{1'b0}};
      req_done_q      <= {NUM_REQ{1'b0}};
      rd_q            <= {(NUM_REQ*DATA_W){1'b0}};
      mem_done_prev_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      win_q           <= win_d;
      grant_q         <= grant_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
      mem_run_q       <= mem_run_d;
      mem_cmd_q       <= mem_cmd_d;
      mem_addr_q      <= mem_addr_d;
      mem_wr_data_q   <= mem_wr_data_d;
      req_done_q      <= req_done_d;
      rd_q            <= rd_d;
      mem_done_prev_q <= mem_done;
    end
  end

  assign req_done    = req_done_q;
  assign req_rd_data = rd_q;
  assign mem_run     = mem_run_q;
  assign mem_cmd     = mem_cmd_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule
